// File: rtl/word_class_scanner_if.sv
// Word stream between a word source and the class scanner.
// The source drives valid/data and the scanner answers with ready.
interface word_class_scanner_if #(
  parameter int WIDTH = 32
);
  logic             valid;
  logic [WIDTH-1:0] data;
  logic             ready;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/word_class_scanner.sv
// Scans a programmed number of words from a valid/ready stream. Each word is
// classified as all-zero, all-ones or mixed. Per-class counts and the longest
// run of consecutive all-zero words are accumulated, then a one-cycle done
// pulse is raised. Results hold until the next accepted start.
module word_class_scanner #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CNT_W-1:0]     len,
  input  logic                 abort,
  word_class_scanner_if.slave  in_bus,
  output logic                 busy,
  output logic                 done,
  output logic                 aborted,
  output logic [CNT_W-1:0]     zero_cnt,
  output logic [CNT_W-1:0]     one_cnt,
  output logic [CNT_W-1:0]     mixed_cnt,
  output logic [CNT_W-1:0]     max_zero_run
);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  state_t           state;
  logic [CNT_W-1:0] remaining;
  logic [CNT_W-1:0] cur_run;
  logic [WIDTH-1:0] word;
  logic             accept;
  logic             word_zero;
  logic             word_one;
  logic [CNT_W-1:0] next_run;

  // in_ready, busy and done are pure decodes of the state register, so the
  // stream handshake never has a combinational path from in_valid.
  assign in_bus.ready = (state == SCAN);
  assign busy         = (state == SCAN);
  assign done         = (state == DONE);

  assign word      = in_bus.data;
  assign accept    = in_bus.valid && (state == SCAN);
  assign word_zero = ~|word;
  assign word_one  = &word;
  assign next_run  = cur_run + CNT_ONE;

  // Sequencing FSM plus the counters it owns; counters only move on accepts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      aborted      <= 1'b0;
      zero_cnt     <= CNT_ZERO;
      one_cnt      <= CNT_ZERO;
      mixed_cnt    <= CNT_ZERO;
      max_zero_run <= CNT_ZERO;
      remaining    <= CNT_ZERO;
      cur_run      <= CNT_ZERO;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            aborted      <= 1'b0;
            zero_cnt     <= CNT_ZERO;
            one_cnt      <= CNT_ZERO;
            mixed_cnt    <= CNT_ZERO;
            max_zero_run <= CNT_ZERO;
            cur_run      <= CNT_ZERO;
            remaining    <= len;
            state        <= (len == CNT_ZERO) ? DONE : SCAN;
          end
        end
        SCAN: begin
          if (accept) begin
            remaining <= remaining - CNT_ONE;
            if (word_zero) begin
              zero_cnt <= zero_cnt + CNT_ONE;
              cur_run  <= next_run;
              if (next_run > max_zero_run) begin
                max_zero_run <= next_run;
              end
            end else begin
              cur_run <= CNT_ZERO;
              if (word_one) begin
                one_cnt <= one_cnt + CNT_ONE;
              end else begin
                mixed_cnt <= mixed_cnt + CNT_ONE;
              end
            end
          end
          if ((accept && (remaining == CNT_ONE)) || abort) begin
            aborted <= abort;
            state   <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_word_class_scanner.sv
// Self-checking bench for word_class_scanner: a table of directed scans,
// hand-written reset / start-ignored / long-scan sequences, and randomized
// scans checked against a simple counting model.
module tb_word_class_scanner;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  len;
  logic        abort;
  logic        busy;
  logic        done;
  logic        aborted;
  logic [7:0]  zero_cnt;
  logic [7:0]  one_cnt;
  logic [7:0]  mixed_cnt;
  logic [7:0]  max_zero_run;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [31:0] word_q[$];
  int          gap_q[$];

  word_class_scanner_if #(.WIDTH(32)) bus ();

  word_class_scanner #(.WIDTH(32), .CNT_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .len          (len),
    .abort        (abort),
    .in_bus       (bus),
    .busy         (busy),
    .done         (done),
    .aborted      (aborted),
    .zero_cnt     (zero_cnt),
    .one_cnt      (one_cnt),
    .mixed_cnt    (mixed_cnt),
    .max_zero_run (max_zero_run)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string name;
    int    scan_len;
    int    n_words;
    logic [7:0][31:0] words;
    int    gaps[8];
    int    abort_idx;
    int    exp_zero;
    int    exp_one;
    int    exp_mixed;
    int    exp_run;
    int    exp_aborted;
    int    exp_latency;
  } vec_t;

  vec_t vecs[5];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Counting model: classifies the words the scan should consume and tracks
  // the longest zero run; latency counts start cycle through done cycle.
  function automatic void modelScan(input int scan_len, input int abort_idx,
                                    output int ez, output int eo, output int em,
                                    output int er, output int ea, output int elat);
    int n;
    int run;
    n = (scan_len == 0) ? 0 : ((abort_idx >= 0) ? abort_idx + 1 : scan_len);
    ez = 0; eo = 0; em = 0; er = 0; run = 0; elat = 2;
    for (int i = 0; i < n; i++) begin
      elat += 1 + gap_q[i];
      if (word_q[i] == 32'h0) begin
        ez++;
        run++;
        if (run > er) er = run;
      end else begin
        run = 0;
        if (word_q[i] == 32'hFFFF_FFFF) eo++;
        else em++;
      end
    end
    ea = (scan_len != 0 && abort_idx >= 0) ? 1 : 0;
  endfunction

  // Runs one scan from IDLE: start, words with gaps, optional abort, and
  // optional start pokes during SCAN and DONE. Ends one cycle after done.
  task automatic applyStimulus(input string name, input int scan_len, input int abort_idx,
                               input bit poke_start, output int latency);
    int n;
    int start_cyc;
    int budget;
    start     = 1'b1;
    len       = 8'(scan_len);
    start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
    len   = 8'($urandom);
    n = (scan_len == 0) ? 0 : ((abort_idx >= 0) ? abort_idx + 1 : scan_len);
    for (int i = 0; i < n; i++) begin
      for (int g = 0; g < gap_q[i]; g++) begin
        bus.valid = 1'b0;
        bus.data  = $urandom;
        @(negedge clk);
      end
      checkOutput({name, ".busy_scan"}, busy, 1'b1);
      bus.valid = 1'b1;
      bus.data  = word_q[i];
      abort     = (i == abort_idx);
      if (poke_start && i == 0) begin
        start = 1'b1;
        len   = 8'd1;
      end
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
    end
    bus.valid = 1'b0;
    budget = 6;
    while (done !== 1'b1 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    checkOutput({name, ".done_seen"}, done, 1'b1);
    latency = cyc - start_cyc + 1;
    checkOutput({name, ".in_ready_done"}, bus.ready, 1'b0);
    if (poke_start) begin
      start = 1'b1;
      len   = 8'd2;
    end
    @(negedge clk);
    start = 1'b0;
    checkOutput({name, ".done_pulse"}, done, 1'b0);
    checkOutput({name, ".busy_idle"}, busy, 1'b0);
  endtask

  task automatic runAndCheck(input string name, input int scan_len, input int abort_idx,
                             input bit poke_start, input int ez, input int eo, input int em,
                             input int er, input int ea, input int elat);
    int lat;
    applyStimulus(name, scan_len, abort_idx, poke_start, lat);
    checkOutput({name, ".zero_cnt"}, zero_cnt, ez);
    checkOutput({name, ".one_cnt"}, one_cnt, eo);
    checkOutput({name, ".mixed_cnt"}, mixed_cnt, em);
    checkOutput({name, ".max_zero_run"}, max_zero_run, er);
    checkOutput({name, ".aborted"}, aborted, ea);
    checkOutput({name, ".latency"}, lat, elat);
    checkOutput({name, ".in_ready_idle"}, bus.ready, 1'b0);
  endtask

  initial begin
    int ez, eo, em, er, ea, elat;
    int r_len, r_abort;
    bit r_poke;

    vecs[0] = '{name: "v_mixed5", scan_len: 5, n_words: 5,
                words: {32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'h1234_5678},
                gaps: '{0, 0, 0, 0, 0, 0, 0, 0}, abort_idx: -1,
                exp_zero: 3, exp_one: 1, exp_mixed: 1, exp_run: 1, exp_aborted: 0, exp_latency: 7};
    vecs[0].words[0] = 32'h0;
    vecs[0].words[1] = 32'h1234_5678;
    vecs[0].words[2] = 32'h0;
    vecs[0].words[3] = 32'hFFFF_FFFF;
    vecs[0].words[4] = 32'h0;
    vecs[1] = '{name: "v_gap6", scan_len: 6, n_words: 6, words: '0,
                gaps: '{0, 0, 3, 0, 0, 0, 0, 0}, abort_idx: -1,
                exp_zero: 5, exp_one: 0, exp_mixed: 1, exp_run: 3, exp_aborted: 0, exp_latency: 11};
    vecs[1].words[3] = 32'h20;
    vecs[2] = '{name: "v_abort", scan_len: 4, n_words: 2, words: '1,
                gaps: '{0, 0, 0, 0, 0, 0, 0, 0}, abort_idx: 1,
                exp_zero: 0, exp_one: 2, exp_mixed: 0, exp_run: 0, exp_aborted: 1, exp_latency: 4};
    vecs[3] = '{name: "v_len0", scan_len: 0, n_words: 0, words: '0,
                gaps: '{0, 0, 0, 0, 0, 0, 0, 0}, abort_idx: -1,
                exp_zero: 0, exp_one: 0, exp_mixed: 0, exp_run: 0, exp_aborted: 0, exp_latency: 2};
    vecs[4] = '{name: "v_abort_last", scan_len: 3, n_words: 3, words: '0,
                gaps: '{0, 1, 0, 0, 0, 0, 0, 0}, abort_idx: 2,
                exp_zero: 3, exp_one: 0, exp_mixed: 0, exp_run: 3, exp_aborted: 1, exp_latency: 6};

    rst       = 1'b1;
    start     = 1'b0;
    len       = 8'd0;
    abort     = 1'b0;
    bus.valid = 1'b0;
    bus.data  = 32'h0;
    repeat (2) @(negedge clk);
    checkOutput("reset.in_ready", bus.ready, 1'b0);
    checkOutput("reset.busy", busy, 1'b0);
    checkOutput("reset.done", done, 1'b0);
    checkOutput("reset.zero_cnt", zero_cnt, 8'd0);
    rst = 1'b0;
    @(negedge clk);

    // Reset in the middle of a len=5 scan after two words.
    start = 1'b1;
    len   = 8'd5;
    @(negedge clk);
    start     = 1'b0;
    bus.valid = 1'b1;
    bus.data  = 32'h0;
    @(negedge clk);
    bus.data  = 32'hFFFF_FFFF;
    @(negedge clk);
    bus.valid = 1'b0;
    checkOutput("midreset.pre_zero", zero_cnt, 8'd1);
    checkOutput("midreset.pre_one", one_cnt, 8'd1);
    checkOutput("midreset.pre_busy", busy, 1'b1);
    #2 rst = 1'b1;
    #1;
    checkOutput("midreset.busy", busy, 1'b0);
    checkOutput("midreset.in_ready", bus.ready, 1'b0);
    checkOutput("midreset.done", done, 1'b0);
    checkOutput("midreset.aborted", aborted, 1'b0);
    checkOutput("midreset.zero_cnt", zero_cnt, 8'd0);
    checkOutput("midreset.one_cnt", one_cnt, 8'd0);
    checkOutput("midreset.mixed_cnt", mixed_cnt, 8'd0);
    checkOutput("midreset.max_zero_run", max_zero_run, 8'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Directed table.
    for (int v = 0; v < 5; v++) begin
      word_q.delete();
      gap_q.delete();
      for (int i = 0; i < vecs[v].n_words; i++) begin
        word_q.push_back(vecs[v].words[i]);
        gap_q.push_back(vecs[v].gaps[i]);
      end
      runAndCheck(vecs[v].name, vecs[v].scan_len, vecs[v].abort_idx, 1'b0,
                  vecs[v].exp_zero, vecs[v].exp_one, vecs[v].exp_mixed,
                  vecs[v].exp_run, vecs[v].exp_aborted, vecs[v].exp_latency);
    end

    // start pulsed during SCAN and DONE must not reload len or clear counts.
    word_q = '{32'h0, 32'hFFFF_FFFF, 32'h5};
    gap_q  = '{0, 0, 0};
    runAndCheck("start_ignored", 3, -1, 1'b1, 1, 1, 1, 1, 0, 5);

    // Longest scan: 255 all-ones words, no wrap.
    word_q.delete();
    gap_q.delete();
    for (int i = 0; i < 255; i++) begin
      word_q.push_back(32'hFFFF_FFFF);
      gap_q.push_back(0);
    end
    runAndCheck("len255", 255, -1, 1'b0, 0, 255, 0, 0, 0, 257);

    // Randomized scans against the counting model.
    for (int t = 0; t < 12; t++) begin
      r_len = $urandom_range(0, 12);
      word_q.delete();
      gap_q.delete();
      for (int i = 0; i < r_len; i++) begin
        case ($urandom_range(0, 3))
          0, 3: word_q.push_back(32'h0);
          1:    word_q.push_back(32'hFFFF_FFFF);
          default: word_q.push_back($urandom);
        endcase
        gap_q.push_back(($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
      end
      r_abort = (r_len > 0 && $urandom_range(0, 3) == 0) ? $urandom_range(0, r_len - 1) : -1;
      r_poke  = 1'($urandom_range(0, 1));
      modelScan(r_len, r_abort, ez, eo, em, er, ea, elat);
      runAndCheck($sformatf("rand%0d", t), r_len, r_abort, r_poke, ez, eo, em, er, ea, elat);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/word_class_scanner.md
# word_class_scanner

Sequencing controller for the 32-bit all-zero/all-ones word detector. On a start command it accepts a programmed number of words over a valid/ready stream and classifies each word as all-zero, all-ones or mixed. It accumulates per-class counts and the longest run of consecutive all-zero words, then reports completion. It sits between a word source (buffer/memory reader) and the status/CSR logic that consumes the counts.

## Interface
Parameters:
- WIDTH, 32, data word width; the all-zero/all-ones detection applies to the full width.
- CNT_W, 8, width of the length field and of every counter.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous reset, active-high.
- start  input  1  start command, sampled only in IDLE.
- len  input  CNT_W  number of words to scan, sampled with start.
- abort  input  1  terminate the scan early, sampled only in SCAN.
- in_valid  input  1  source has a word on in_data.
- in_data  input  WIDTH  word to classify.
- in_ready  output  1  scanner accepts a word this cycle.
- busy  output  1  high in SCAN.
- done  output  1  one-cycle completion pulse.
- aborted  output  1  last scan ended by abort; held until next start.
- zero_cnt  output  CNT_W  count of accepted all-zero words.
- one_cnt  output  CNT_W  count of accepted all-ones words.
- mixed_cnt  output  CNT_W  count of accepted words that are neither.
- max_zero_run  output  CNT_W  longest run of consecutive accepted all-zero words.

## Operation
- States: IDLE, SCAN, DONE. Reset enters IDLE.
- Reset values: in_ready=0, busy=0, done=0, aborted=0, all counters=0, internal remaining/current-run registers=0.
- IDLE: start=1 with len≠0 → SCAN. At the same time, clear all counters, aborted and the current run, and load remaining=len. start=1 with len=0 → DONE directly, with counters cleared and aborted=0. start=0 → stay in IDLE.
- SCAN: in_ready=1 and busy=1. An accept is in_valid & in_ready. On each accept:
  - Classify in_data. zero = ~|in_data; one = &in_data; mixed = neither.
  - Increment exactly one of zero_cnt, one_cnt or mixed_cnt.
  - Decrement remaining.
  - If the word is zero: cur_run+1, and max_zero_run = max(max_zero_run, cur_run+1). Otherwise cur_run=0.
- SCAN exits to DONE on an accept with remaining==1, or on abort=1. If abort and an accept occur in the same cycle, count the word, then go to DONE with aborted=1. An abort on the final accept also sets aborted=1.
- DONE: done=1 for exactly one cycle, in_ready=0, then go to IDLE unconditionally. start is ignored in DONE.
- start outside IDLE is ignored. abort outside SCAN is ignored.
- Counters hold their final values from DONE until the next accepted start.
- Counters cannot overflow, because every count is ≤ len ≤ 2^CNT_W−1. No saturation logic is needed.
- Asynchronous reset mid-scan returns to IDLE and clears everything immediately. The partial result is lost.

## Timing
- start accepted at edge t → busy=1 and in_ready=1 from t+1.
- A word presented with in_valid at cycle c, while in_ready=1, is counted at the edge ending c. Updated counters are visible in cycle c+1.
- One word per cycle at full throughput. in_valid gaps stall the scan without penalty.
- Final accept in cycle k → done=1 in cycle k+1, IDLE in k+2. A new start is accepted in k+2 at the earliest.
- Total latency with zero-gap input is len+2 cycles from the start edge to the done cycle.
- start with len=0 → done in the cycle after start.
- in_ready depends on state only. It has no combinational path from in_valid.
- All outputs are registered or decoded from the state register.

## Test plan
- Reset: assert rst mid-SCAN after 2 of 5 words → all outputs 0 in the same cycle, state IDLE, and the next start works normally.
- len=5 with words 0, 12345678, 0, FFFFFFFF, 0 back-to-back → zero_cnt=3, one_cnt=1, mixed_cnt=1, max_zero_run=1, done exactly 7 cycles after the start edge, aborted=0.
- len=6 with words 0, 0, 0, 20, 0, 0, and in_valid deasserted for 3 cycles between the 2nd and 3rd words → zero_cnt=5, mixed_cnt=1, max_zero_run=3, and done delayed by 3 cycles.
- len=4, abort asserted in the same cycle as the accept of word 2 (FFFFFFFF, FFFFFFFF) → one_cnt=2, done the next cycle, aborted=1, and in_ready low afterward.
- start with len=0 → done in the cycle after start, all counts 0, in_ready never high.
- start pulsed during SCAN and DONE → ignored: len is not reloaded and counts are not cleared. len=255 of all-ones words → one_cnt=255 with no wrap.
